// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame controller slice.
//   BinW / MagW : FFT bin index and magnitude widths
//   NPointsDef  : default samples per FFT frame
//   fft_state_e : frame controller state encoding
//   bin_dist()  : absolute distance between two bin indices
package fft_pkg;

   localparam int unsigned BinW       = 11;
   localparam int unsigned MagW       = 28;
   localparam int unsigned NPointsDef = 2048;

   typedef logic [BinW-1:0] bin_t;
   typedef logic [MagW-1:0] mag_t;

   typedef enum logic [2:0] {
      StIdle,
      StSkip,
      StCapture,
      StProcess,
      StReport
   } fft_state_e;

   function automatic bin_t bin_dist(input bin_t a, input bin_t b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Handshake bundle between the frame controller and the FFT core.
//   fft_adc_valid       : gated sample strobe into the FFT (controller -> core)
//   fft_enable          : FFT enable (controller -> core)
//   fft_ready_for_data  : core can accept a sample (core -> controller)
//   fft_processing_done : core finished the transform (core -> controller)
//   fft_magnitude_valid : fft_bin_index / fft_magnitude carry a result (core -> controller)
// Modports: master = controller side, slave = FFT core side.
interface fft_frame_ctrl_if;
   import fft_pkg::*;

   logic fft_adc_valid;
   logic fft_enable;
   logic fft_ready_for_data;
   logic fft_processing_done;
   logic fft_magnitude_valid;
   bin_t fft_bin_index;
   mag_t fft_magnitude;

   modport master (
      output fft_adc_valid,
      output fft_enable,
      input  fft_ready_for_data,
      input  fft_processing_done,
      input  fft_magnitude_valid,
      input  fft_bin_index,
      input  fft_magnitude
   );

   modport slave (
      input  fft_adc_valid,
      input  fft_enable,
      output fft_ready_for_data,
      output fft_processing_done,
      output fft_magnitude_valid,
      output fft_bin_index,
      output fft_magnitude
   );

endinterface

// File: rtl/fft_peak2_track.sv
// Tracks the two largest FFT magnitudes, keeping peak2 at least GUARD_BINS+1 bins from peak1.
//   clk, rst            : clock, synchronous active-high reset
//   clear               : zero both peaks (start of a new frame)
//   mag_valid, bin, mag : candidate result; only MIN_BIN <= bin < N_POINTS/2 is considered
//   peak1_*/peak2_*     : current largest / second largest (bin, magnitude)
module fft_peak2_track
   import fft_pkg::*;
#(
   parameter int unsigned N_POINTS   = NPointsDef,
   parameter int unsigned MIN_BIN    = 1,
   parameter int unsigned GUARD_BINS = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic mag_valid,
   input  bin_t bin,
   input  mag_t mag,
   output bin_t peak1_bin,
   output mag_t peak1_mag,
   output bin_t peak2_bin,
   output mag_t peak2_mag
);

   localparam bin_t MinBin   = bin_t'(MIN_BIN);
   localparam bin_t BinLimit = bin_t'(N_POINTS / 2);
   localparam bin_t Guard    = bin_t'(GUARD_BINS);

   logic in_range;
   logic far;

   // Only the non-mirrored half of the spectrum is searched.
   assign in_range = mag_valid && (bin >= MinBin) && (bin < BinLimit);
   assign far      = bin_dist(bin, peak1_bin) > Guard;

   // Strict compares: an equal magnitude never displaces the earlier (lower) bin.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         peak1_bin <= '0;
         peak1_mag <= '0;
         peak2_bin <= '0;
         peak2_mag <= '0;
      end else if (in_range) begin
         if (mag > peak1_mag) begin
            if (far) begin
               peak2_bin <= peak1_bin;
               peak2_mag <= peak1_mag;
            end
            peak1_bin <= bin;
            peak1_mag <= mag;
         end else if ((mag > peak2_mag) && far) begin
            peak2_bin <= bin;
            peak2_mag <= mag;
         end
      end
   end

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT frame controller: discards SKIP_SAMPLES leading ADC samples, forwards N_POINTS samples
// to the FFT core, then tracks the two strongest bins of the result and reports them.
//   clk, rst          : clock, synchronous active-high reset
//   start / cont      : frame request pulse / re-arm after each report
//   abort             : cancel the current frame (no result)
//   adc_valid_in      : ADC sample strobe
//   fft               : FFT core handshake bundle (master modport)
//   peak1_* / peak2_* : strongest / second strongest bin and magnitude
//   result_valid      : one-cycle pulse while the frame result is reported
//   busy              : frame in progress
//   timeout_err       : one-cycle pulse when the FFT core never finishes
//   frame_cnt         : completed frames, wrapping
// Build option: define FFT_FRAME_CTRL_WDOG_EN to enable the PROCESS-state watchdog.
module fft_frame_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned N_POINTS     = NPointsDef,
   parameter int unsigned SKIP_SAMPLES = 352,
   parameter int unsigned MIN_BIN      = 1,
   parameter int unsigned GUARD_BINS   = 2,
   parameter int unsigned TIMEOUT_CYC  = 200000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont,
   input  logic              abort,
   input  logic              adc_valid_in,
   fft_frame_ctrl_if.master  fft,
   output bin_t              peak1_bin,
   output mag_t              peak1_mag,
   output bin_t              peak2_bin,
   output mag_t              peak2_mag,
   output logic              result_valid,
   output logic              busy,
   output logic              timeout_err,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned CntMax = (N_POINTS > SKIP_SAMPLES) ? N_POINTS : SKIP_SAMPLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] SkipLast = CntW'((SKIP_SAMPLES == 0) ? 0 : SKIP_SAMPLES - 1);
   localparam logic [CntW-1:0] CaptLast = CntW'(N_POINTS - 1);
   // With nothing to discard a frame starts straight in CAPTURE.
   localparam fft_state_e EntrySt = (SKIP_SAMPLES == 0) ? StCapture : StSkip;

   if (TIMEOUT_CYC == 0 || N_POINTS < 2 || N_POINTS / 2 > (1 << BinW)) begin : g_param_check
      $error("fft_frame_ctrl: unsupported parameter set");
   end

   fft_state_e      state_q;
   logic [CntW-1:0] smp_cnt_q;
   logic            fwd;
   logic            clear_peaks;
   logic            track_valid;

   assign fwd               = adc_valid_in && fft.fft_ready_for_data && (state_q == StCapture);
   assign fft.fft_adc_valid = fwd;
   assign fft.fft_enable    = (state_q != StIdle);
   assign busy              = (state_q != StIdle);

   // Peaks restart whenever a new frame is armed, from IDLE or by re-arm out of REPORT.
   always_comb begin
      clear_peaks = 1'b0;
      if (!abort) begin
         if ((state_q == StIdle) && start) clear_peaks = 1'b1;
         if ((state_q == StReport) && cont) clear_peaks = 1'b1;
      end
   end

   assign track_valid = fft.fft_magnitude_valid && (state_q == StProcess) && !abort;

`ifdef FFT_FRAME_CTRL_WDOG_EN
   localparam int unsigned WdogW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYC - 1);

   logic [WdogW-1:0] wdog_cnt_q;
   logic             timeout_q;

   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         smp_cnt_q    <= '0;
         frame_cnt    <= '0;
         result_valid <= 1'b0;
`ifdef FFT_FRAME_CTRL_WDOG_EN
         wdog_cnt_q   <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
`ifdef FFT_FRAME_CTRL_WDOG_EN
         timeout_q    <= 1'b0;
         // Counts cycles spent in PROCESS; restarts from 0 on every entry.
         wdog_cnt_q   <= (state_q == StProcess) ? wdog_cnt_q + 1'b1 : '0;
`endif
         if (abort) begin
            state_q   <= StIdle;
            smp_cnt_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q   <= EntrySt;
                     smp_cnt_q <= '0;
                  end
               end
               StSkip: begin
                  if (adc_valid_in) begin
                     if (smp_cnt_q == SkipLast) begin
                        state_q   <= StCapture;
                        smp_cnt_q <= '0;
                     end else begin
                        smp_cnt_q <= smp_cnt_q + 1'b1;
                     end
                  end
               end
               StCapture: begin
                  // Strobes the core cannot accept are dropped and not counted.
                  if (fwd) begin
                     if (smp_cnt_q == CaptLast) begin
                        state_q   <= StProcess;
                        smp_cnt_q <= '0;
                     end else begin
                        smp_cnt_q <= smp_cnt_q + 1'b1;
                     end
                  end
               end
               StProcess: begin
                  if (fft.fft_processing_done) begin
                     state_q      <= StReport;
                     result_valid <= 1'b1;
                     frame_cnt    <= frame_cnt + 16'd1;
                  end
`ifdef FFT_FRAME_CTRL_WDOG_EN
                  else if (wdog_cnt_q == WdogLast) begin
                     state_q   <= StIdle;
                     timeout_q <= 1'b1;
                  end
`endif
               end
               StReport: begin
                  state_q   <= cont ? EntrySt : StIdle;
                  smp_cnt_q <= '0;
               end
               default: begin
                  state_q   <= StIdle;
                  smp_cnt_q <= '0;
               end
            endcase
         end
      end
   end

   fft_peak2_track #(
      .N_POINTS   (N_POINTS),
      .MIN_BIN    (MIN_BIN),
      .GUARD_BINS (GUARD_BINS)
   ) u_peak2_track (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_peaks),
      .mag_valid (track_valid),
      .bin       (fft.fft_bin_index),
      .mag       (fft.fft_magnitude),
      .peak1_bin (peak1_bin),
      .peak1_mag (peak1_mag),
      .peak2_bin (peak2_bin),
      .peak2_mag (peak2_mag)
   );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with default frame geometry and TIMEOUT_CYC = 1000.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_fft_frame_ctrl;
   import fft_pkg::*;

   localparam int unsigned TimeoutCyc = 1000;

   logic        clk = 1'b0;
   logic        rst, start, cont, abort, adc_valid_in;
   bin_t        peak1_bin, peak2_bin;
   mag_t        peak1_mag, peak2_mag;
   logic        result_valid, busy, timeout_err;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   fft_frame_ctrl_if fft_bus ();

   fft_frame_ctrl #(
      .TIMEOUT_CYC (TimeoutCyc)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cont         (cont),
      .abort        (abort),
      .adc_valid_in (adc_valid_in),
      .fft          (fft_bus),
      .peak1_bin    (peak1_bin),
      .peak1_mag    (peak1_mag),
      .peak2_bin    (peak2_bin),
      .peak2_mag    (peak2_mag),
      .result_valid (result_valid),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // 2400 strobes with the core always ready: SKIP then a full CAPTURE, ending in PROCESS.
   task automatic feed_frame();
      fft_bus.fft_ready_for_data = 1'b1;
      for (int i = 0; i < 2400; i++) begin
         adc_valid_in = 1'b1;
         tick();
      end
      adc_valid_in = 1'b0;
   endtask

   task automatic send_mag(input int b, input int m, input logic done);
      fft_bus.fft_magnitude_valid = 1'b1;
      fft_bus.fft_bin_index       = bin_t'(b);
      fft_bus.fft_magnitude       = mag_t'(m);
      fft_bus.fft_processing_done = done;
      tick();
      fft_bus.fft_magnitude_valid = 1'b0;
      fft_bus.fft_processing_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, fft_bus.fft_enable, result_valid, timeout_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b, expected 0000",
                  {busy, fft_bus.fft_enable, result_valid, timeout_err});
      end
      checks++;
      if ({peak1_bin, peak1_mag, peak2_bin, peak2_mag, frame_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_values: got p1=%0h/%0h p2=%0h/%0h cnt=%0h, expected all 0",
                  peak1_bin, peak1_mag, peak2_bin, peak2_mag, frame_cnt);
      end
   endtask

   task automatic test_capture();
      int fwd_cnt = 0;
      int first   = 0;
      start_frame();
      checks++;
      if ({busy, fft_bus.fft_enable} !== 2'b11) begin
         errors++;
         $display("FAIL armed_flags: got %b, expected 11", {busy, fft_bus.fft_enable});
      end
      fft_bus.fft_ready_for_data = 1'b1;
      for (int i = 1; i <= 2400; i++) begin
         adc_valid_in = 1'b1;
         start = (i == 100);  // must be ignored outside IDLE
         #1;
         if (fft_bus.fft_adc_valid === 1'b1) begin
            fwd_cnt++;
            if (first == 0) first = i;
         end
         tick();
      end
      start = 1'b0;
      checks++;
      if (fwd_cnt != 2048) begin
         errors++;
         $display("FAIL fwd_count: got %0d, expected 2048", fwd_cnt);
      end
      checks++;
      if (first != 353) begin
         errors++;
         $display("FAIL first_fwd: got strobe %0d, expected 353", first);
      end
      #1;
      checks++;
      if ({busy, fft_bus.fft_adc_valid} !== 2'b10) begin
         errors++;
         $display("FAIL process_gate: got busy/adc_valid %b, expected 10",
                  {busy, fft_bus.fft_adc_valid});
      end
      adc_valid_in = 1'b0;
   endtask

   task automatic test_peaks_basic();
      send_mag(0, 28'hFFFFFFF, 1'b0);
      send_mag(1024, 28'hFFFFFFF, 1'b0);
      for (int b = 1; b < 1023; b++) begin
         send_mag(b, (b == 123) ? 28'h800000 : (b == 246) ? 28'h400000 : 28'h10, 1'b0);
      end
      checks++;
      if (result_valid !== 1'b0) begin
         errors++;
         $display("FAIL early_result: got %b, expected 0", result_valid);
      end
      send_mag(1023, 28'h10, 1'b1);
      checks++;
      if ({result_valid, frame_cnt} !== {1'b1, 16'd1}) begin
         errors++;
         $display("FAIL report1: got valid=%b cnt=%0d, expected valid=1 cnt=1",
                  result_valid, frame_cnt);
      end
      checks++;
      if ({peak1_bin, peak1_mag, peak2_bin, peak2_mag} !==
          {11'd123, 28'h800000, 11'd246, 28'h400000}) begin
         errors++;
         $display("FAIL peaks1: got p1=%0d/%0h p2=%0d/%0h, expected 123/800000 246/400000",
                  peak1_bin, peak1_mag, peak2_bin, peak2_mag);
      end
      tick();
      checks++;
      if ({result_valid, busy, peak1_bin, peak2_bin} !== {1'b0, 1'b0, 11'd123, 11'd246}) begin
         errors++;
         $display("FAIL after_report1: got valid=%b busy=%b p1=%0d p2=%0d, expected 0 0 123 246",
                  result_valid, busy, peak1_bin, peak2_bin);
      end
   endtask

   task automatic test_peaks_guard();
      int exp_cnt = 0;
      int bad     = 0;
      logic rdy, exp_fwd;
      start_frame();
      // One strobe in three is refused by the core during capture.
      for (int i = 1; i <= 3600; i++) begin
         rdy     = (i % 3 != 0);
         exp_fwd = (i > 352) && rdy && (exp_cnt < 2048);
         adc_valid_in               = 1'b1;
         fft_bus.fft_ready_for_data = rdy;
         #1;
         if (fft_bus.fft_adc_valid !== exp_fwd) bad++;
         if (exp_fwd) exp_cnt++;
         tick();
      end
      adc_valid_in               = 1'b0;
      fft_bus.fft_ready_for_data = 1'b1;
      checks++;
      if (bad != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ready_drop: got %0d gating errors busy=%b, expected 0 and 1", bad, busy);
      end
      send_mag(0, 28'hFFFFFFF, 1'b0);
      send_mag(123, 28'h800000, 1'b0);
      send_mag(124, 28'h7F0000, 1'b0);
      send_mag(1024, 28'hFFFFFFF, 1'b0);
      send_mag(300, 28'h100, 1'b1);  // update coincides with done
      checks++;
      if ({result_valid, frame_cnt} !== {1'b1, 16'd2}) begin
         errors++;
         $display("FAIL report2: got valid=%b cnt=%0d, expected valid=1 cnt=2",
                  result_valid, frame_cnt);
      end
      checks++;
      if ({peak1_bin, peak1_mag, peak2_bin, peak2_mag} !==
          {11'd123, 28'h800000, 11'd300, 28'h100}) begin
         errors++;
         $display("FAIL peaks_guard: got p1=%0d/%0h p2=%0d/%0h, expected 123/800000 300/100",
                  peak1_bin, peak1_mag, peak2_bin, peak2_mag);
      end
      tick();
   endtask

   task automatic test_abort();
      int rv_seen = 0;
      start_frame();
      fft_bus.fft_ready_for_data = 1'b1;
      for (int i = 1; i <= 352 + 999; i++) begin
         adc_valid_in = 1'b1;
         tick();
      end
      abort = 1'b1;  // 1000th capture sample
      tick();
      abort = 1'b0;
      #1;
      checks++;
      if ({busy, fft_bus.fft_enable, result_valid, fft_bus.fft_adc_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_capture: got busy/en/valid/fwd %b, expected 0000",
                  {busy, fft_bus.fft_enable, result_valid, fft_bus.fft_adc_valid});
      end
      adc_valid_in = 1'b0;
      // Abort beats done in the same PROCESS cycle.
      start_frame();
      feed_frame();
      fft_bus.fft_processing_done = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (result_valid === 1'b1) rv_seen++;
         tick();
      end
      fft_bus.fft_processing_done = 1'b0;
      checks++;
      if (rv_seen != 0 || busy !== 1'b0 || frame_cnt !== 16'd2) begin
         errors++;
         $display("FAIL abort_done: got %0d result pulses busy=%b cnt=%0d, expected 0 0 2",
                  rv_seen, busy, frame_cnt);
      end
   endtask

   task automatic test_reset_mid();
      start_frame();
      feed_frame();
      send_mag(50, 28'h1234, 1'b0);
      checks++;
      if ({peak1_bin, peak1_mag} !== {11'd50, 28'h1234}) begin
         errors++;
         $display("FAIL pre_reset_peak: got %0d/%0h, expected 50/1234", peak1_bin, peak1_mag);
      end
      rst = 1'b1;
      abort = 1'b1;
      start = 1'b1;
      fft_bus.fft_processing_done = 1'b1;
      tick();
      rst = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      fft_bus.fft_processing_done = 1'b0;
      checks++;
      if ({busy, fft_bus.fft_enable, result_valid, timeout_err} !== 4'b0000 ||
          {peak1_bin, peak1_mag, peak2_bin, peak2_mag, frame_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got flags=%b p1=%0d/%0h p2=%0d/%0h cnt=%0d, expected all 0",
                  {busy, fft_bus.fft_enable, result_valid, timeout_err},
                  peak1_bin, peak1_mag, peak2_bin, peak2_mag, frame_cnt);
      end
   endtask

   task automatic test_cont();
      cont = 1'b1;
      start_frame();
      feed_frame();
      send_mag(10, 28'h500, 1'b0);
      send_mag(20, 28'h500, 1'b0);
      send_mag(12, 28'h600, 1'b1);
      checks++;
      if ({result_valid, frame_cnt, peak1_bin, peak1_mag, peak2_bin, peak2_mag} !==
          {1'b1, 16'd1, 11'd12, 28'h600, 11'd20, 28'h500}) begin
         errors++;
         $display("FAIL cont_frame1: got valid=%b cnt=%0d p1=%0d/%0h p2=%0d/%0h, expected 1 1 12/600 20/500",
                  result_valid, frame_cnt, peak1_bin, peak1_mag, peak2_bin, peak2_mag);
      end
      tick();
      cont = 1'b0;
      checks++;
      if ({busy, result_valid, peak1_mag} !== {1'b1, 1'b0, 28'h0}) begin
         errors++;
         $display("FAIL rearm: got busy=%b valid=%b p1mag=%0h, expected 1 0 0",
                  busy, result_valid, peak1_mag);
      end
      feed_frame();  // already in SKIP, no start pulse
      send_mag(5, 28'h50, 1'b1);
      checks++;
      if ({result_valid, frame_cnt, peak1_bin, peak1_mag, peak2_bin, peak2_mag} !==
          {1'b1, 16'd2, 11'd5, 28'h50, 11'd0, 28'h0}) begin
         errors++;
         $display("FAIL cont_frame2: got valid=%b cnt=%0d p1=%0d/%0h p2=%0d/%0h, expected 1 2 5/50 0/0",
                  result_valid, frame_cnt, peak1_bin, peak1_mag, peak2_bin, peak2_mag);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL cont_stop: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_watchdog();
      int hit     = 0;
      int rv_seen = 0;
      start_frame();
      feed_frame();
`ifdef FFT_FRAME_CTRL_WDOG_EN
      for (int k = 1; k <= 1200 && hit == 0; k++) begin
         tick();
         if (result_valid === 1'b1) rv_seen++;
         if (timeout_err === 1'b1) hit = k;
      end
      checks++;
      if (hit != 1000 || busy !== 1'b0 || rv_seen != 0) begin
         errors++;
         $display("FAIL wdog_fire: got cycle %0d busy=%b results=%0d, expected 1000 0 0",
                  hit, busy, rv_seen);
      end
      tick();
      checks++;
      if ({timeout_err, busy} !== 2'b00) begin
         errors++;
         $display("FAIL wdog_pulse: got err/busy %b, expected 00", {timeout_err, busy});
      end
`else
      for (int k = 1; k <= 1200; k++) begin
         tick();
         if (timeout_err !== 1'b0 || busy !== 1'b1) hit++;
         if (result_valid === 1'b1) rv_seen++;
      end
      checks++;
      if (hit != 0 || rv_seen != 0) begin
         errors++;
         $display("FAIL no_wdog_wait: got %0d bad cycles %0d results, expected 0 0", hit, rv_seen);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL no_wdog_abort: got busy=%b, expected 0", busy);
      end
`endif
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      cont = 1'b0;
      abort = 1'b0;
      adc_valid_in = 1'b0;
      fft_bus.fft_ready_for_data  = 1'b1;
      fft_bus.fft_processing_done = 1'b0;
      fft_bus.fft_magnitude_valid = 1'b0;
      fft_bus.fft_bin_index       = '0;
      fft_bus.fft_magnitude       = '0;
      test_reset();
      test_capture();
      test_peaks_basic();
      test_peaks_guard();
      test_abort();
      test_reset_mid();
      test_cont();
      test_watchdog();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
